// File: rtl/zynq_shell_fifo_reducer.sv
// Join-and-reduce engine between the shell's ps_to_pl and pl_to_ps FIFOs.
// Each channel dequeues one word from each of its arity_p inputs and emits add/xor/max or an N-group accumulation.
module zynq_shell_fifo_reducer #(
    parameter int data_width_p  = 32,
    parameter int num_out_p     = 2,
    parameter int arity_p       = 2,
    parameter int count_width_p = 16
) (
    input  logic                                            aclk,
    input  logic                                            aresetn,
    input  logic [1:0]                                      mode_i,
    input  logic [count_width_p-1:0]                        acc_len_i,
    input  logic [num_out_p*arity_p-1:0][data_width_p-1:0]  in_data_i,
    input  logic [num_out_p*arity_p-1:0]                    in_v_i,
    output logic [num_out_p*arity_p-1:0]                    in_yumi_o,
    output logic [num_out_p-1:0][data_width_p-1:0]          out_data_o,
    output logic [num_out_p-1:0]                            out_v_o,
    input  logic [num_out_p-1:0]                            out_ready_i,
    output logic [num_out_p-1:0][count_width_p-1:0]         count_o,
    output logic                                            busy_o
);

    // state | meaning
    // IDLE  | no accumulation in progress; next fire latches mode and length
    // ACC   | mid-accumulation; mode/length frozen until the final group
    typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_e;

    logic [num_out_p-1:0] busy_ch;

    for (genvar k = 0; k < num_out_p; k++) begin : g_ch
        state_e                   state_q, state_d;
        logic [1:0]               mode_q, mode_d;
        logic [count_width_p-1:0] len_q, len_d;
        logic [count_width_p-1:0] acc_cnt_q, acc_cnt_d;
        logic [count_width_p-1:0] count_q, count_d;
        logic [data_width_p-1:0]  acc_q, acc_d;
        logic [data_width_p-1:0]  out_q, out_d;
        logic                     out_v_q, out_v_d;

        logic [data_width_p-1:0]  grp_sum, grp_xor, grp_max, grp_val;
        logic [1:0]               mode_eff;
        logic [count_width_p-1:0] len_eff;
        logic [count_width_p:0]   cnt_inc;
        logic                     all_v, out_space, final_grp, fire, drain;

        always_comb begin
            grp_sum = '0;
            grp_xor = '0;
            grp_max = '0;
            all_v   = 1'b1;
            for (int i = 0; i < arity_p; i++) begin
                grp_sum = grp_sum + in_data_i[k*arity_p+i];
                grp_xor = grp_xor ^ in_data_i[k*arity_p+i];
                if (in_data_i[k*arity_p+i] > grp_max) grp_max = in_data_i[k*arity_p+i];
                all_v   = all_v & in_v_i[k*arity_p+i];
            end
        end

        // Handshake and decode; in IDLE the live CSR inputs decide, in ACC the latched copies do.
        always_comb begin
            mode_eff  = (state_q == IDLE) ? mode_i : mode_q;
            if (state_q == IDLE)
                len_eff = (acc_len_i == '0) ? count_width_p'(1) : acc_len_i;
            else
                len_eff = len_q;
            cnt_inc   = {1'b0, acc_cnt_q} + {{count_width_p{1'b0}}, 1'b1};
            if (state_q == IDLE)
                final_grp = (mode_i != 2'd3) || (len_eff == count_width_p'(1));
            else
                final_grp = cnt_inc >= {1'b0, len_q};
            case (mode_eff)
                2'd1:    grp_val = grp_xor;
                2'd2:    grp_val = grp_max;
                default: grp_val = grp_sum;
            endcase
            out_space = ~out_v_q | out_ready_i[k];
            fire      = aresetn & all_v & (~final_grp | out_space);
            drain     = out_v_q & out_ready_i[k];
        end

        always_comb begin
            state_d   = state_q;
            mode_d    = mode_q;
            len_d     = len_q;
            acc_cnt_d = acc_cnt_q;
            acc_d     = acc_q;
            out_d     = out_q;
            out_v_d   = out_v_q & ~drain;
            count_d   = count_q + count_width_p'(drain);
            if (fire) begin
                if (state_q == IDLE) begin
                    mode_d = mode_i;
                    len_d  = len_eff;
                    if (final_grp) begin
                        out_d   = grp_val;
                        out_v_d = 1'b1;
                    end else begin
                        acc_d     = grp_val;
                        acc_cnt_d = count_width_p'(1);
                        state_d   = ACC;
                    end
                end else if (final_grp) begin
                    out_d   = acc_q + grp_val;
                    out_v_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    acc_d     = acc_q + grp_val;
                    acc_cnt_d = cnt_inc[count_width_p-1:0];
                end
            end
        end

        always_ff @(posedge aclk) begin
            if (!aresetn) begin
                state_q   <= IDLE;
                mode_q    <= '0;
                len_q     <= '0;
                acc_cnt_q <= '0;
                acc_q     <= '0;
                out_q     <= '0;
                out_v_q   <= 1'b0;
                count_q   <= '0;
            end else begin
                state_q   <= state_d;
                mode_q    <= mode_d;
                len_q     <= len_d;
                acc_cnt_q <= acc_cnt_d;
                acc_q     <= acc_d;
                out_q     <= out_d;
                out_v_q   <= out_v_d;
                count_q   <= count_d;
            end
        end

        assign in_yumi_o[k*arity_p +: arity_p] = {arity_p{fire}};
        assign out_data_o[k] = out_q;
        assign out_v_o[k]    = out_v_q;
        assign count_o[k]    = count_q;
        assign busy_ch[k]    = out_v_q | (state_q == ACC);
    end

    assign busy_o = |busy_ch;

endmodule

// File: doc/zynq_shell_fifo_reducer.md
# zynq_shell_fifo_reducer

Parametrised join-and-reduce engine that sits between the ps_to_pl and pl_to_ps FIFO ports of bsg_zynq_pl_shell, and replaces the fixed pairwise-add loopback. Each output channel joins `arity_p` ps_to_pl FIFOs and combines one word from each with a CSR-selected operator: add, xor, unsigned max, or add-accumulate over N groups. A registered output stage provides backpressure toward the pl_to_ps FIFOs. Per-channel output counters are exported for readback as pl_to_ps CSRs.

## Interface
- `data_width_p`, 32: width of every data word.
- `num_out_p`, 2: number of output channels (pl_to_ps FIFOs).
- `arity_p`, 2: inputs joined per output channel; must be ≥ 1. Input count is `num_out_p*arity_p`.
- `count_width_p`, 16: width of the accumulate length and of the output counters.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: reset, synchronous, active-low. Clock is `aclk`.
- `mode_i` in 2: operator select. 0 = add, 1 = xor, 2 = unsigned max, 3 = accumulate.
- `acc_len_i` in `count_width_p`: number of groups per output word in mode 3. A value of 0 is treated as 1.
- `in_data_i` in `num_out_p*arity_p` × `data_width_p`: ps_to_pl FIFO data.
- `in_v_i` in `num_out_p*arity_p`: ps_to_pl FIFO valid.
- `in_yumi_o` out `num_out_p*arity_p`: dequeue strobe to the ps_to_pl FIFOs.
- `out_data_o` out `num_out_p` × `data_width_p`: data to the pl_to_ps FIFOs.
- `out_v_o` out `num_out_p`: output valid.
- `out_ready_i` in `num_out_p`: pl_to_ps FIFO ready.
- `count_o` out `num_out_p` × `count_width_p`: outputs delivered per channel.
- `busy_o` out 1: OR over all channels of (output register full or accumulation in progress).

## Operation
- Channel k owns inputs `k*arity_p` through `k*arity_p+arity_p-1`. Channels are fully independent.
- Group fire: a channel fires a group when all of its `arity_p` inputs are valid AND the channel can accept the group. On fire, `in_yumi_o` is asserted for all of the channel's inputs in the same cycle. Partial dequeue never occurs.
- Group value:
  - Mode 0: sum modulo 2^`data_width_p`.
  - Mode 1: bitwise xor.
  - Mode 2: unsigned maximum.
  - Mode 3: sum modulo 2^`data_width_p`.
- Each channel has two states: IDLE (no accumulation in progress) and ACC (mid-accumulation). It also has a one-entry output register `out_r`/`out_v_r`.
- `out_space` = `~out_v_r | out_ready_i`.
- IDLE, fire:
  - Latch `mode_i` into `mode_r` and latch the effective length L = max(`acc_len_i`, 1).
  - If `mode_r` ≠ 3 or L = 1: the group is final. It requires `out_space`, and its value loads `out_r`, setting `out_v_r`.
  - Otherwise: `acc_r` ← group value, `acc_cnt_r` ← 1, go to ACC. This fire does not require `out_space`.
- ACC, fire:
  - Non-final group (`acc_cnt_r`+1 < L): `acc_r` += group value and `acc_cnt_r` increments. Requires no `out_space`.
  - Final group: requires `out_space`. `out_r` ← `acc_r` + group value, `out_v_r` ← 1, return to IDLE.
- `mode_i` and `acc_len_i` changes during ACC are ignored until the channel returns to IDLE.
- Output handshake: `out_v_o` = `out_v_r`. On `out_v_o & out_ready_i`, `out_v_r` clears unless reloaded in the same cycle. A simultaneous drain and load keeps `out_v_r` = 1 with the new data.
- `count_o[k]` increments on each `out_v_o[k] & out_ready_i[k]`. It wraps from all-ones to 0.
- Reset:
  - While `aresetn` = 0: `in_yumi_o` = 0 (gated combinationally).
  - On a clock edge with `aresetn` = 0: `out_v_r` = 0, `out_r` = 0, `count_o` = 0, `acc_r` = 0, `acc_cnt_r` = 0, state = IDLE, `mode_r` = 0.
  - Reset mid-accumulation discards the partial sum.

## Timing
- `in_yumi_o` is combinational from `in_v_i`, `out_ready_i`, and channel state. There is no combinational path from `in_data_i` to any output.
- Latency from final-group fire to `out_v_o` is 1 cycle.
- Throughput is one group per cycle per channel, including back-to-back outputs when `out_ready_i` is held high.
- Mode 3 with length L: first output appears L cycles after the first fire, given continuous input.
- Reset values: `out_v_o` = 0, `out_data_o` = 0, `count_o` = 0, `busy_o` = 0, `in_yumi_o` = 0.

## Test plan
- Mode 0, defaults (`num_out_p` = 2, `arity_p` = 2): inputs 0,1 = 3, 4 and inputs 2,3 = 0xFFFFFFFF, 1.
  - Required: out0 = 7 and out1 = 0 (wrap), both one cycle after yumi.
  - Required: `count_o` = {1,1}.
- Modes 1 and 2 on inputs 0xF0F0_0000 and 0x0FF0_0001.
  - Required: xor = 0xFF00_0001.
  - Required: max = 0xF0F0_0000.
- Mode 3, `acc_len_i` = 3, groups (1,2), (3,4), (5,6) on consecutive cycles.
  - Required: a single output of 21.
  - Changing `mode_i` to 0 after the first group must not alter the result.
  - `acc_len_i` = 0 must behave as length 1.
- Backpressure: hold `out_ready_i` = 0 with inputs valid.
  - Required: exactly one output is captured and `in_yumi_o` is then 0.
  - Release ready: drain and reload occur in the same cycle with no bubble.
  - One input channel is invalid: no yumi on that group's other inputs.
- Reset mid-accumulate: `acc_len_i` = 4, assert reset after 2 groups, then run 4 groups of (1,1).
  - Required: output = 8.
  - Required: `count_o` restarts at 0, then reads 1.
- Counter wrap: `count_width_p` = 4 with 17 outputs.
  - Required: `count_o` = 1.
